// File: rtl/mm_buf_xbar_if.sv
// Core-side and buffer-side signal bundle of the matrix-multiply buffer crossbar.
// slave is the crossbar view; master is the core plus buffers around it.
interface mm_buf_xbar_if #(
    parameter int NUM_BUF    = 4,
    parameter int NUM_WR_BUF = 2,
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 11,
    parameter int INST_W     = 128
);
    logic [INST_W-1:0]            inst;
    logic                         start;
    logic                         start_ready;
    logic                         done;
    logic                         err;
    logic                         core_done;

    logic                         core_in_avalid;
    logic [ADDR_W-1:0]            core_in_addr;
    logic                         core_in_valid;
    logic [DATA_W-1:0]            core_in_data;

    logic                         core_acc_avalid;
    logic [ADDR_W-1:0]            core_acc_addr;
    logic                         core_acc_aready;
    logic                         core_acc_valid;
    logic [DATA_W-1:0]            core_acc_data;

    logic                         core_out_valid;
    logic [ADDR_W-1:0]            core_out_addr;
    logic [DATA_W-1:0]            core_out_data;

    logic [NUM_BUF-1:0]           buf_rd_avalid;
    logic [NUM_BUF*ADDR_W-1:0]    buf_rd_addr;
    logic [NUM_BUF-1:0]           buf_rd_valid;
    logic [NUM_BUF*DATA_W-1:0]    buf_rd_data;

    logic [NUM_WR_BUF-1:0]        buf_wr_valid;
    logic [NUM_WR_BUF*ADDR_W-1:0] buf_wr_addr;
    logic [NUM_WR_BUF*DATA_W-1:0] buf_wr_data;

    modport slave (
        input  inst, start, core_done,
        input  core_in_avalid, core_in_addr,
        input  core_acc_avalid, core_acc_addr,
        input  core_out_valid, core_out_addr, core_out_data,
        input  buf_rd_valid, buf_rd_data,
        output start_ready, done, err,
        output core_in_valid, core_in_data,
        output core_acc_aready, core_acc_valid, core_acc_data,
        output buf_rd_avalid, buf_rd_addr,
        output buf_wr_valid, buf_wr_addr, buf_wr_data
    );

    modport master (
        output inst, start, core_done,
        output core_in_avalid, core_in_addr,
        output core_acc_avalid, core_acc_addr,
        output core_out_valid, core_out_addr, core_out_data,
        output buf_rd_valid, buf_rd_data,
        input  start_ready, done, err,
        input  core_in_valid, core_in_data,
        input  core_acc_aready, core_acc_valid, core_acc_data,
        input  buf_rd_avalid, buf_rd_addr,
        input  buf_wr_valid, buf_wr_addr, buf_wr_data
    );
endinterface

// File: rtl/mm_buf_xbar.sv
// Buffer crossbar: routes core input/accumulate reads and result writes to
// the selected feature buffers, arbitrates a shared read port, tags responses.
module mm_buf_xbar #(
    parameter int NUM_BUF    = 4,
    parameter int NUM_WR_BUF = 2,
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 11,
    parameter int RD_LAT     = 2,
    parameter int INST_W     = 128
) (
    input  logic          clk,
    input  logic          rstn,
    mm_buf_xbar_if.slave  bus
);
    localparam int WB0 = NUM_BUF - NUM_WR_BUF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    logic [NUM_BUF-1:0]     r_in_sel;
    logic [NUM_WR_BUF-1:0]  r_out_sel;
    logic [RD_LAT-1:0]      r_tag_in;
    logic [RD_LAT-1:0]      r_tag_acc;
    logic                   r_done;
    logic                   r_err;

    logic [NUM_BUF-1:0]           w_new_in_sel;
    logic [NUM_WR_BUF-1:0]        w_new_out_sel;
    logic                         w_sel_ok;
    logic [NUM_BUF-1:0]           w_acc_gsel;
    logic                         w_active;
    logic                         w_in_iss;
    logic                         w_conflict;
    logic                         w_acc_rdy;
    logic                         w_acc_iss;
    logic                         w_tag_in;
    logic                         w_tag_acc;
    logic [NUM_BUF-1:0]           w_exp_vld;
    logic                         w_tag_err;
    logic                         w_pipe_empty;
    logic [NUM_BUF-1:0]           w_rd_avalid;
    logic [NUM_BUF*ADDR_W-1:0]    w_rd_addr;
    logic [DATA_W-1:0]            w_in_data;
    logic [DATA_W-1:0]            w_acc_data;
    logic [NUM_WR_BUF-1:0]        w_wr_valid;
    logic [NUM_WR_BUF*ADDR_W-1:0] w_wr_addr;
    logic [NUM_WR_BUF*DATA_W-1:0] w_wr_data;
    logic                         w_unused;

    assign w_new_in_sel  = bus.inst[1 +: NUM_BUF];
    assign w_new_out_sel = bus.inst[9 +: NUM_WR_BUF];
    assign w_sel_ok      = $onehot(w_new_in_sel) && $onehot(w_new_out_sel);
    assign w_unused      = ^bus.inst;

    // writable buffers occupy the top indices of the read-port space
    assign w_acc_gsel = NUM_BUF'(r_out_sel) << WB0;
    assign w_active   = (r_state != S_IDLE);
    assign w_in_iss   = w_active & bus.core_in_avalid;
    assign w_conflict = w_in_iss & (|(r_in_sel & w_acc_gsel));
    assign w_acc_rdy  = w_active & ~w_conflict;
    assign w_acc_iss  = w_acc_rdy & bus.core_acc_avalid;

    assign w_tag_in     = r_tag_in[RD_LAT-1];
    assign w_tag_acc    = r_tag_acc[RD_LAT-1];
    assign w_exp_vld    = ({NUM_BUF{w_tag_in}} & r_in_sel)
                        | ({NUM_BUF{w_tag_acc}} & w_acc_gsel);
    assign w_tag_err    = |(w_exp_vld ^ bus.buf_rd_valid);
    assign w_pipe_empty = ~|{r_tag_in, r_tag_acc, w_in_iss, w_acc_iss};

    always_comb begin
        w_rd_avalid = '0;
        w_rd_addr   = '0;
        w_in_data   = '0;
        w_acc_data  = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            if (w_acc_iss && w_acc_gsel[k]) begin
                w_rd_avalid[k]                 = 1'b1;
                w_rd_addr[k*ADDR_W +: ADDR_W]  = bus.core_acc_addr;
            end else if (w_active && r_in_sel[k]) begin
                w_rd_avalid[k]                 = bus.core_in_avalid;
                w_rd_addr[k*ADDR_W +: ADDR_W]  = bus.core_in_addr;
            end
            if (w_tag_in && r_in_sel[k])
                w_in_data = w_in_data | bus.buf_rd_data[k*DATA_W +: DATA_W];
            if (w_tag_acc && w_acc_gsel[k])
                w_acc_data = w_acc_data | bus.buf_rd_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_wr_valid = '0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        for (int j = 0; j < NUM_WR_BUF; j++) begin
            if (w_active && r_out_sel[j]) begin
                w_wr_valid[j]                 = bus.core_out_valid;
                w_wr_addr[j*ADDR_W +: ADDR_W] = bus.core_out_addr;
                w_wr_data[j*DATA_W +: DATA_W] = bus.core_out_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag_in  <= '0;
            r_tag_acc <= '0;
        end else begin
            r_tag_in[0]  <= w_in_iss;
            r_tag_acc[0] <= w_acc_iss;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag_in[s]  <= r_tag_in[s-1];
                r_tag_acc[s] <= r_tag_acc[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_in_sel  <= '0;
            r_out_sel <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tag_err)
                r_err <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && w_sel_ok) begin
                        r_in_sel  <= w_new_in_sel;
                        r_out_sel <= w_new_out_sel;
                        r_err     <= 1'b0;
                        r_state   <= S_RUN;
                    end else if (bus.start) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.core_done)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready     = (r_state == S_IDLE);
    assign bus.done            = r_done;
    assign bus.err             = r_err;
    assign bus.core_acc_aready = w_acc_rdy;
    assign bus.core_in_valid   = w_tag_in;
    assign bus.core_in_data    = w_in_data;
    assign bus.core_acc_valid  = w_tag_acc;
    assign bus.core_acc_data   = w_acc_data;
    assign bus.buf_rd_avalid   = w_rd_avalid;
    assign bus.buf_rd_addr     = w_rd_addr;
    assign bus.buf_wr_valid    = w_wr_valid;
    assign bus.buf_wr_addr     = w_wr_addr;
    assign bus.buf_wr_data     = w_wr_data;
endmodule

// File: doc/mm_buf_xbar.md
Name: mm_buf_xbar

Overview:
- Parametrised buffer crossbar between the matrix-multiply core and the on-chip feature buffers.
- Latches the instruction on start. Routes core input reads to one of NUM_BUF read ports, and routes core accumulate reads and result writes to one of NUM_WR_BUF writable buffers.
- Arbitrates the shared read port when input and accumulate reads target the same buffer, and tags returned data so each response reaches the correct requester.
- Generates done and error status for the layer.

Parameters:
- NUM_BUF, 4, number of readable buffers; must be ≤ 8.
- NUM_WR_BUF, 2, writable buffers; these are buffer indices NUM_BUF-NUM_WR_BUF .. NUM_BUF-1.
- DATA_W, 512, buffer word width.
- ADDR_W, 11, buffer address width.
- RD_LAT, 2, fixed buffer read latency in cycles; must be ≥ 1.
- INST_W, 128, instruction width.

Ports:
- clk  in  1  kernel clock
- rstn  in  1  asynchronous active-low reset
- inst  in  INST_W  instruction; in_sel = inst[1 +: NUM_BUF], out_sel = inst[9 +: NUM_WR_BUF]
- start  in  1  start request
- start_ready  out  1  high in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag
- core_done  in  1  core finished issuing
- core_in_avalid / core_in_addr  in  1 / ADDR_W  input read request
- core_in_valid / core_in_data  out  1 / DATA_W  input read response
- core_acc_avalid / core_acc_addr  in  1 / ADDR_W  accumulate read request
- core_acc_aready  out  1  accumulate request accepted
- core_acc_valid / core_acc_data  out  1 / DATA_W  accumulate read response
- core_out_valid / core_out_addr / core_out_data  in  1 / ADDR_W / DATA_W  result write
- buf_rd_avalid  out  NUM_BUF  per-buffer read strobe
- buf_rd_addr  out  NUM_BUF*ADDR_W  per-buffer read address, flattened
- buf_rd_valid  in  NUM_BUF  per-buffer read response valid
- buf_rd_data  in  NUM_BUF*DATA_W  per-buffer read data, flattened
- buf_wr_valid  out  NUM_WR_BUF  per-buffer write strobe
- buf_wr_addr  out  NUM_WR_BUF*ADDR_W  per-buffer write address, flattened
- buf_wr_data  out  NUM_WR_BUF*DATA_W  per-buffer write data, flattened

Behaviour:
- Reset: FSM=IDLE, latched selects=0, tag pipe cleared, err=0, done=0. All buffer strobes, addresses and data outputs are 0 because they are gated by the latched selects.
- FSM states: IDLE, RUN, DRAIN.
- IDLE→RUN on start & start_ready when in_sel and out_sel are both exactly one-hot. The FSM latches both selects and clears err.
- If either select is not one-hot (zero or multi-hot) at start: err=1, done pulses the next cycle, FSM stays IDLE, no buffer access occurs.
- RUN→DRAIN on core_done. DRAIN→IDLE when the tag pipe is empty; done pulses that same cycle.
- Input read, zero-cycle path: buf_rd_avalid[i]=core_in_avalid and buf_rd_addr[i]=core_in_addr for the selected input buffer i. Every other buffer is driven 0.
- Accumulate read targets the selected write buffer j (global index NUM_BUF-NUM_WR_BUF+j).
  - If core_in_avalid is high and the input buffer is the same physical buffer, the input read wins and core_acc_aready=0 (stall).
  - Otherwise core_acc_aready=1 during RUN/DRAIN, and the request drives that buffer's port.
  - core_acc_aready=0 in IDLE.
- Tag pipe: RD_LAT stages of {in_issued, acc_issued}, shifted every cycle. At the pipe output:
  - core_in_valid/core_in_data are taken from buffer i when in_issued.
  - core_acc_valid/core_acc_data are taken from buffer j when acc_issued.
  - Both can be valid in the same cycle only when the two buffers differ.
- Tag check: a pipe-output bit set while the corresponding buf_rd_valid is low, or buf_rd_valid high with no tag, sets err (sticky). The response is still forwarded per the tag.
- Write path: buf_wr_valid[j]=core_out_valid, with addr/data passed through. Writes are forwarded in RUN and DRAIN and are never stalled. A write and a read to the same buffer in one cycle are both forwarded; the buffer defines the ordering.
- Requests from the core in IDLE are ignored (no strobes).
- start during RUN/DRAIN is ignored; inst is sampled only on an accepted start.
- Reset mid-operation: outputs return to reset values immediately and in-flight tags are discarded.

Test Plan:
- Normal layer: in_sel=0001, out_sel=01; 4 input reads at addr 0..3 → buf_rd_avalid[0] pulses, core_in_valid 2 cycles later with buffer-0 data. Four writes hit buf_wr_valid[0]. core_done → done pulses once the pipe is empty (≥2 cycles later).
- Shared port: in_sel=0100, out_sel=01, in and acc requests in the same cycle → core_acc_aready=0 and only the input address reaches buffer 2. The next cycle the acc request is accepted; the responses arrive on separate cycles, routed correctly.
- Separate ports: in_sel=0001, out_sel=10, in and acc requests in the same cycle → both accepted. core_in_valid and core_acc_valid are asserted together 2 cycles later with buffer-0 and buffer-3 data respectively.
- Illegal select: in_sel=0011 with start → err=1, done pulse, no buf_rd_avalid. A following legal start clears err.
- Tag mismatch: a buffer returns valid one cycle late → err=1 and stays set through done.
- Reset mid-RUN with 2 reads in flight → all outputs 0, start_ready=1, no stale core_in_valid after reset release.
